sprite_motion_ctrl: RTL and testbench

- Parametrised successor to the single-step, fixed-screen player movement logic in the game top level.
- Converts four direction buttons into a sprite top-left position (pos_x, pos_y) for the image ROM reader / draw stage.
- Adds a programmable game tick, acceleration from STEP_MIN to STEP_MAX, opposite-direction cancellation and sprite-size-aware bounds.
- Sits between the board inputs and the sprite renderer, clocked by the pixel clock.

---
 rtl/sprite_motion_ctrl.sv | 124 ++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: tick-paced accelerating sprite mover with bounds clamp (define SPRITE_WRAP_EN for toroidal wrap)
module sprite_motion_ctrl #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int SCREEN_W = 1280,
  parameter int SCREEN_H = 800,
  parameter int SPR_W = 140,
  parameter int SPR_H = 100,
  parameter int INIT_X = 520,
  parameter int INIT_Y = 300,
  parameter int TICK_DIV = 524288,
  parameter int STEP_MIN = 1,
  parameter int STEP_MAX = 8,
  parameter int ACCEL_TICKS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_up,
  input  logic          in_down,
  input  logic          in_left,
  input  logic          in_right,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          tick,
  output logic          moving,
  output logic [3:0]    at_edge
);
  localparam int XMAX = SCREEN_W - SPR_W;
  localparam int YMAX = SCREEN_H - SPR_H;
  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [3:0] EDGE0 = {INIT_Y == 0, INIT_Y == YMAX, INIT_X == 0, INIT_X == XMAX};
  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [SW-1:0] step, step_n, mv;
  logic [HW-1:0] hold, hold_n;
  logic upd, active, x_neg, x_over, y_neg, y_over;
  logic signed [1:0] dx, dy;
  logic [XW+1:0] sx, cx, x_lo, x_hi;
  logic [YW+1:0] sy, cy, y_lo, y_hi;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  assign upd = cnt == CW'(TICK_DIV - 1);
  assign dx = $signed({1'b0, in_right}) - $signed({1'b0, in_left});
  assign dy = $signed({1'b0, in_down}) - $signed({1'b0, in_up});
  assign active = (dx != 2'sd0) || (dy != 2'sd0);
  // While accelerating, the move on a step-increment tick already uses the incremented step
  always_comb begin
    state_n = state;
    step_n = step;
    hold_n = hold;
    mv = '0;
    if (!active) begin
      state_n = IDLE;
      step_n = SW'(STEP_MIN);
      hold_n = '0;
    end else if (state == IDLE) begin
      mv = SW'(STEP_MIN);
      hold_n = '0;
      state_n = (STEP_MIN == STEP_MAX) ? CRUISE : ACCEL;
    end else if (state == ACCEL) begin
      if (hold == HW'(ACCEL_TICKS - 1)) begin
        step_n = step + 1'b1;
        hold_n = '0;
        state_n = (step_n == SW'(STEP_MAX)) ? CRUISE : ACCEL;
      end else begin
        hold_n = hold + 1'b1;
      end
      mv = step_n;
    end else begin
      mv = SW'(STEP_MAX);
    end
  end
  always_comb begin
    sx = (XW+2)'(mv);
    sy = (YW+2)'(mv);
    cx = {2'b00, pos_x} + (dx == 2'sd1 ? sx : dx == -2'sd1 ? -sx : '0);
    cy = {2'b00, pos_y} + (dy == 2'sd1 ? sy : dy == -2'sd1 ? -sy : '0);
    x_neg = cx[XW+1];
    y_neg = cy[YW+1];
    x_over = !x_neg && cx[XW:0] > (XW+1)'(XMAX);
    y_over = !y_neg && cy[YW:0] > (YW+1)'(YMAX);
`ifdef SPRITE_WRAP_EN
    x_lo = cx + (XW+2)'(XMAX + 1);
    x_hi = cx - (XW+2)'(XMAX + 1);
    y_lo = cy + (YW+2)'(YMAX + 1);
    y_hi = cy - (YW+2)'(YMAX + 1);
`else
    x_lo = '0;
    x_hi = (XW+2)'(XMAX);
    y_lo = '0;
    y_hi = (YW+2)'(YMAX);
`endif
    nx = x_neg ? x_lo[XW-1:0] : x_over ? x_hi[XW-1:0] : cx[XW-1:0];
    ny = y_neg ? y_lo[YW-1:0] : y_over ? y_hi[YW-1:0] : cy[YW-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tick <= 1'b0;
      state <= IDLE;
      step <= SW'(STEP_MIN);
      hold <= '0;
      pos_x <= XW'(INIT_X);
      pos_y <= YW'(INIT_Y);
      moving <= 1'b0;
      at_edge <= EDGE0;
    end else begin
      cnt <= upd ? '0 : cnt + 1'b1;
      tick <= upd;
      if (upd) begin
        state <= state_n;
        step <= step_n;
        hold <= hold_n;
        pos_x <= nx;
        pos_y <= ny;
        moving <= state_n != IDLE;
        at_edge <= {ny == '0, ny == YW'(YMAX), nx == '0, nx == XW'(XMAX)};
      end
    end
  end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: scoreboarded random and directed checks of sprite_motion_ctrl with a fast tick
module tb_sprite_motion_ctrl;
  localparam int TD = 4, SMIN = 1, SMAX = 3, AT = 2;
  localparam int XMAX = 1140, YMAX = 700, IX = 520, IY = 300;
  typedef struct {int x; int y; int mv; int e;} exp_t;
  logic clk = 0, rst = 1, in_up = 0, in_down = 0, in_left = 0, in_right = 0;
  logic [10:0] pos_x;
  logic [9:0] pos_y;
  logic tick, moving;
  logic [3:0] at_edge;
  int passed = 0, total = 0;
  int mc = 0, mx = IX, my = IY, k = 0;
  exp_t q[$];
  sprite_motion_ctrl #(.TICK_DIV(TD), .STEP_MIN(SMIN), .STEP_MAX(SMAX), .ACCEL_TICKS(AT)) dut (
    .clk(clk), .rst(rst), .in_up(in_up), .in_down(in_down), .in_left(in_left), .in_right(in_right),
    .pos_x(pos_x), .pos_y(pos_y), .tick(tick), .moving(moving), .at_edge(at_edge)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask
  function automatic int fix(int c, int m);
`ifdef SPRITE_WRAP_EN
    return c < 0 ? c + m + 1 : c > m ? c - m - 1 : c;
`else
    return c < 0 ? 0 : c > m ? m : c;
`endif
  endfunction
  // Reference: step depends only on how many consecutive ticks a direction has been held
  always @(posedge clk) begin
    int dx, dy, s;
    if (rst) begin
      mc = 0; mx = IX; my = IY; k = 0;
      q.delete();
    end else if (mc == TD - 1) begin
      mc = 0;
      dx = int'(in_right) - int'(in_left);
      dy = int'(in_down) - int'(in_up);
      if (dx != 0 || dy != 0) begin
        k++;
        s = SMIN + (k - 1) / AT;
        if (s > SMAX) s = SMAX;
        mx = fix(mx + dx * s, XMAX);
        my = fix(my + dy * s, YMAX);
      end else k = 0;
      q.push_back('{mx, my, int'(k > 0),
        (int'(my == 0) << 3) | (int'(my == YMAX) << 2) | (int'(mx == 0) << 1) | int'(mx == XMAX)});
    end else mc++;
  end
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("tick_timing", int'(tick), int'(q.size() != 0));
      if (tick && q.size() != 0) begin
        e = q.pop_front();
        chk("sb_pos_x", int'(pos_x), e.x);
        chk("sb_pos_y", int'(pos_y), e.y);
        chk("sb_moving", int'(moving), e.mv);
        chk("sb_at_edge", int'(at_edge), e.e);
      end
    end
  end
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    if (!tick) begin
      total++;
      $display("FAIL tick_timeout: got no tick expected tick within 20 cycles");
    end
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  initial begin
    int rx[6] = '{521, 522, 524, 526, 529, 532};
    @(negedge clk);
    @(negedge clk);
    chk("rst_pos_x", int'(pos_x), IX);
    chk("rst_pos_y", int'(pos_y), IY);
    chk("rst_tick", int'(tick), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_at_edge", int'(at_edge), 0);
    rst = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("first_tick", int'(tick), int'(i == 4));
    end
    repeat (36) @(negedge clk);
    chk("idle_pos_x", int'(pos_x), IX);
    chk("idle_pos_y", int'(pos_y), IY);
    chk("idle_moving", int'(moving), 0);
    in_right = 1;
    do_reset();
    foreach (rx[i]) begin
      wait_tick();
      chk("right_seq", int'(pos_x), rx[i]);
      chk("right_moving", int'(moving), 1);
    end
    in_right = 0;
    wait_tick();
    chk("release_pos_x", int'(pos_x), 532);
    chk("release_moving", int'(moving), 0);
    in_right = 1;
    wait_tick();
    chk("repress_pos_x", int'(pos_x), 533);
    repeat (5) wait_tick();
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("upd_rst_pos_x", int'(pos_x), IX);
    chk("upd_rst_pos_y", int'(pos_y), IY);
    chk("upd_rst_tick", int'(tick), 0);
    chk("upd_rst_moving", int'(moving), 0);
    rst = 0;
    wait_tick();
    chk("post_rst_pos_x", int'(pos_x), IX + 1);
    in_right = 0;
    in_up = 1;
    in_down = 1;
    do_reset();
    repeat (5) begin
      wait_tick();
      chk("updown_pos_y", int'(pos_y), IY);
      chk("updown_moving", int'(moving), 0);
    end
    in_up = 0;
    in_down = 0;
    in_left = 1;
    do_reset();
`ifdef SPRITE_WRAP_EN
    begin
      int t = 0;
      while (pos_x != 1 && t < 300) begin
        wait_tick();
        t++;
      end
      wait_tick();
      chk("wrap_left", int'(pos_x), XMAX - 1);
    end
`else
    repeat (200) wait_tick();
    chk("clamp_left_pos_x", int'(pos_x), 0);
    chk("clamp_left_edge", int'(at_edge[1]), 1);
`endif
    in_left = 0;
    for (int i = 0; i < 400; i++) begin
      {in_up, in_down, in_left, in_right} = 4'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
      end
      repeat ($urandom_range(1, 24)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
